// File: rtl/serial_adder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : serial_adder_pkg
//  Description : Shared constants and state type for the bit-serial adder.
//  Revision    : 1.0 - initial release
// ============================================================================
package serial_adder_pkg;

  // Operand width used when the top is instantiated without overrides.
  localparam int DEFAULT_WIDTH = 8;

  // Controller state encoding.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  // 2'd3 is unreachable; the controller steers it back to idle.
  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE,
    S_SHIFT = ST_SHIFT,
    S_DONE  = ST_DONE,
    S_BAD   = 2'd3
  } state_t;

endpackage : serial_adder_pkg
`default_nettype wire

// File: rtl/fulladder_beha.sv
`default_nettype none
// ============================================================================
//  Module      : fulladder_beha
//  Description : Single-bit behavioural full adder (s = a^b^c, carry-out).
//  Revision    : 1.0 - initial release
// ============================================================================
module fulladder_beha (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic s,
  output logic cout
);

  logic w_p;

  assign w_p  = a ^ b;
  assign s    = w_p ^ c;
  assign cout = (a & b) | (c & w_p);

endmodule : fulladder_beha
`default_nettype wire

// File: rtl/serial_adder.sv
`default_nettype none
// ============================================================================
//  Module      : serial_adder
//  Description : Bit-serial WIDTH-bit adder, LSB first, one full-adder cell
//                plus a carry flop. Start/busy/done handshake; the result
//                registers only change on the completion edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int               CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_ra;
  logic [WIDTH-1:0] r_rb;
  logic             r_carry;
  logic [WIDTH-1:0] r_psum;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;

  logic             w_s_fa;
  logic             w_cout_fa;
  logic             w_accept;
  logic             w_shift;
  logic             w_last;
  logic [WIDTH-1:0] w_psum_nxt;

  // The single full-adder cell works on the current LSBs and the carry flop.
  fulladder_beha u_fa (
    .a    (r_ra[0]),
    .b    (r_rb[0]),
    .c    (r_carry),
    .s    (w_s_fa),
    .cout (w_cout_fa)
  );

  // New work is only taken when no operation is in flight.
  assign w_accept   = start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_shift    = (r_state == S_SHIFT);
  assign w_last     = (r_cnt == CNT_LAST);
  assign w_psum_nxt = {w_s_fa, r_psum[WIDTH-1:1]};

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode; the illegal encoding falls back to idle.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_SHIFT;
      S_SHIFT: if (w_last) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = start ? S_SHIFT : S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Operand capture, bit-serial shifting and result update on the last bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt   <= '0;
      r_ra    <= '0;
      r_rb    <= '0;
      r_carry <= 1'b0;
      r_psum  <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
    end else if (w_accept) begin
      r_ra    <= a;
      r_rb    <= b;
      r_carry <= cin;
      r_cnt   <= '0;
    end else if (w_shift) begin
      r_carry <= w_cout_fa;
      r_ra    <= r_ra >> 1;
      r_rb    <= r_rb >> 1;
      r_psum  <= w_psum_nxt;
      r_cnt   <= r_cnt + CNT_ONE;
      if (w_last) begin
        r_sum  <= w_psum_nxt;
        r_cout <= w_cout_fa;
      end
    end
  end

  assign busy = (r_state == S_SHIFT);
  assign done = (r_state == S_DONE);
  assign sum  = r_sum;
  assign cout = r_cout;

endmodule : serial_adder
`default_nettype wire
